// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: three-state round-robin arbiter driving a 4:1 mux select/enable with hold timeout
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       en1_n,
  output logic       en2_n,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t     state_q;
  logic [1:0] ptr_q, sel_q, pick;
  logic [3:0] grant_q;
  logic [7:0] cnt_q;
  logic       en_n_q, busy_q, timeout_q, rel, lim;
  always_comb begin
    pick = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (req[ptr_q + 2'(k)]) pick = ptr_q + 2'(k);
  end
  assign rel = |(grant_q & (done | ~req));
  assign lim = cnt_q == 8'(MAX_HOLD - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          state_q <= GRANT;
          grant_q <= 4'(1) << pick;
          sel_q   <= pick;
          en_n_q  <= 1'b0;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        GRANT: if (rel || lim) begin
          state_q   <= RELEASE;
          grant_q   <= '0;
          en_n_q    <= 1'b1;
          timeout_q <= !rel;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        RELEASE: begin
          state_q <= IDLE;
          ptr_q   <= sel_q + 2'd1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign grant   = grant_q;
  assign sel     = sel_q;
  assign en1_n   = en_n_q;
  assign en2_n   = en_n_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed-vector bench for the round-robin mux arbiter
module tb_mux_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       en1_n, en2_n, busy, timeout;
  logic [9:0] obs;
  logic       mon_en = 1'b0;
  logic [3:0] prev_g = '0;
  logic [1:0] prev_s = '0;
  int         vectors = 0;
  int         miscompares = 0;
  mux_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant), .sel(sel),
    .en1_n(en1_n), .en2_n(en2_n), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  assign obs = {grant, sel, en1_n, en2_n, busy, timeout};
  always @(negedge clk) begin
    if (mon_en) begin
      if (!$onehot0(grant)) begin
        miscompares++;
        $display("FAIL onehot grant=%b", grant);
      end
      if (en1_n !== en2_n) begin
        miscompares++;
        $display("FAIL en_equal en1_n=%b en2_n=%b", en1_n, en2_n);
      end
      if (prev_g != 0 && grant != 0 && sel !== prev_s) begin
        miscompares++;
        $display("FAIL sel_stable sel=%b was=%b", sel, prev_s);
      end
      prev_g <= grant;
      prev_s <= sel;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b1;
    tick();
    tick();
    e = {4'b0000, 2'b00, 4'b1100};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset got=%b exp=%b", obs, e);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    tick();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL reset_idle got=%b exp=%b", obs, e);
    end
  endtask
  task automatic test_single();
    logic [9:0] e;
    req = 4'b0100;
    tick();
    e = {4'b0100, 2'b10, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL single_grant got=%b exp=%b", obs, e);
    end
    tick();
    tick();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL single_hold got=%b exp=%b", obs, e);
    end
    done = 4'b0100;
    tick();
    e = {4'b0000, 2'b10, 4'b1110};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL single_release got=%b exp=%b", obs, e);
    end
    done = 4'b0000;
    req = 4'b1101;
    tick();
    e = {4'b0000, 2'b10, 4'b1100};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL single_idle got=%b exp=%b", obs, e);
    end
    tick();
    e = {4'b1000, 2'b11, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL ptr_after_release got=%b exp=%b", obs, e);
    end
    req = 4'b0000;
    tick();
    e = {4'b0000, 2'b11, 4'b1110};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL req_drop_release got=%b exp=%b", obs, e);
    end
    tick();
  endtask
  task automatic test_back_to_back();
    logic [3:0] g;
    logic [1:0] s;
    logic [9:0] e;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      s = 2'(i % 4);
      g = 4'b0001 << s;
      tick();
      e = {g, s, 4'b0010};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL b2b_grant%0d got=%b exp=%b", i, obs, e);
      end
      done = g;
      tick();
      e = {4'b0000, s, 4'b1110};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL b2b_release%0d got=%b exp=%b", i, obs, e);
      end
      done = 4'b0000;
      if (i == 4) req = 4'b0000;
      tick();
      e = {4'b0000, s, 4'b1100};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL b2b_idle%0d got=%b exp=%b", i, obs, e);
      end
    end
  endtask
  task automatic test_timeout();
    logic [9:0] e;
    req = 4'b0010;
    tick();
    e = {4'b0010, 2'b01, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL to_grant got=%b exp=%b", obs, e);
    end
    for (int k = 2; k <= 8; k++) begin
      tick();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL to_hold%0d got=%b exp=%b", k, obs, e);
      end
    end
    tick();
    e = {4'b0000, 2'b01, 4'b1111};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL to_pulse got=%b exp=%b", obs, e);
    end
    tick();
    e = {4'b0000, 2'b01, 4'b1100};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL to_pulse_end got=%b exp=%b", obs, e);
    end
    tick();
    e = {4'b0010, 2'b01, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL to_regrant got=%b exp=%b", obs, e);
    end
    req = 4'b0000;
    tick();
    e = {4'b0000, 2'b01, 4'b1110};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL to_normal_release got=%b exp=%b", obs, e);
    end
    tick();
  endtask
  task automatic test_done_at_limit();
    logic [9:0] e;
    req = 4'b0010;
    tick();
    e = {4'b0010, 2'b01, 4'b0010};
    for (int k = 2; k <= 8; k++) begin
      tick();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL limit_hold%0d got=%b exp=%b", k, obs, e);
      end
    end
    done = 4'b0010;
    tick();
    e = {4'b0000, 2'b01, 4'b1110};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL limit_done_release got=%b exp=%b", obs, e);
    end
    done = 4'b0000;
    req = 4'b0000;
    tick();
  endtask
  task automatic test_mid_reset();
    logic [9:0] e;
    req = 4'b1000;
    tick();
    e = {4'b1000, 2'b11, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL mr_grant got=%b exp=%b", obs, e);
    end
    tick();
    rst = 1'b1;
    req = 4'b1001;
    tick();
    e = {4'b0000, 2'b00, 4'b1100};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL mid_reset got=%b exp=%b", obs, e);
    end
    rst = 1'b0;
    tick();
    e = {4'b0001, 2'b00, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL post_reset_req0 got=%b exp=%b", obs, e);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask
  task automatic test_ignore_others();
    logic [9:0] e;
    req = 4'b0100;
    tick();
    e = {4'b0100, 2'b10, 4'b0010};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL ig_grant got=%b exp=%b", obs, e);
    end
    req = 4'b0111;
    done = 4'b1011;
    tick();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL ig_other_done got=%b exp=%b", obs, e);
    end
    req = 4'b1100;
    done = 4'b0001;
    tick();
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL ig_other_req got=%b exp=%b", obs, e);
    end
    done = 4'b0100;
    tick();
    e = {4'b0000, 2'b10, 4'b1110};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL ig_release got=%b exp=%b", obs, e);
    end
    done = 4'b0000;
    req = 4'b0000;
    tick();
    tick();
    tick();
    e = {4'b0000, 2'b10, 4'b1100};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL idle_sel_hold got=%b exp=%b", obs, e);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_at_limit();
    test_mid_reset();
    test_ignore_others();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
